// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared IFU definitions: fetch FSM state encoding and the default reset PC.
package ysyx_22041412_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_REQ   = 2'd1,
    IFU_WAIT  = 2'd2,
    IFU_DRAIN = 2'd3
  } ifu_state_e;

  // Redirect targets arrive as 64-bit values; only a word-aligned 32-bit PC is kept.
  function automatic logic [31:0] ifu_align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22041412_ifu_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries with flush and occupancy count.
// Flush overrides push/pop in the same cycle. Caller guarantees no push when full, no pop when empty.
module ysyx_22041412_ifu_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [63:0]              data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [63:0]              data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][63:0] mem_q;
  logic [AW-1:0]          rd_q, wr_q;
  logic [AW:0]            cnt_q;

  // Pointer/count update with flush taking priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one request outstanding to
// instruction memory, buffers responses and hands {pc, instr} to decode.
// Redirect / fence.i flush the buffer and discard any in-flight response.
// Optional: define YSYX_22041412_IFU_PERF_EN to add delivered/stall counters.
module ysyx_22041412_ifu
  import ysyx_22041412_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        fence_i_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o
`ifdef YSYX_22041412_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt_o,
  output logic [63:0] perf_stall_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e    state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;

  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] cnt_after_pop;
  logic [63:0]   fifo_head;
  logic          fifo_empty;
  logic          flush, req_hs, push, pop;
  logic          credit_idle, credit_push;
  logic [31:0]   flush_pc;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^{redirect_pc_i[63:32], redirect_pc_i[1:0]};

  assign flush  = redirect_valid_i | fence_i_i;
  // fence.i refetches the oldest buffered instruction, else continues at fetch_pc.
  assign flush_pc = redirect_valid_i ? ifu_align_pc(redirect_pc_i[31:0])
                  : (fifo_empty ? fetch_pc_q : fifo_head[63:32]);
  assign req_hs = (state_q == IFU_REQ) & imem_req_ready_i;
  assign push   = (state_q == IFU_WAIT) & imem_resp_valid_i & ~flush;
  assign pop    = out_valid_o & out_ready_i;

  // Credit: buffered entries plus the outstanding request must fit the FIFO.
  assign cnt_after_pop = fifo_cnt - CW'(pop);
  assign credit_idle   = fifo_cnt < CW'(FIFO_DEPTH);
  assign credit_push   = cnt_after_pop < CW'(FIFO_DEPTH - 1);

  // Fetch FSM and PC bookkeeping; flush overrides all normal transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFU_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else if (flush) begin
      fetch_pc_q <= flush_pc;
      case (state_q)
        IFU_REQ:   state_q <= req_hs ? IFU_DRAIN : IFU_REQ;
        IFU_WAIT:  state_q <= imem_resp_valid_i ? IFU_REQ : IFU_DRAIN;
        IFU_DRAIN: state_q <= imem_resp_valid_i ? IFU_REQ : IFU_DRAIN;
        default:   state_q <= IFU_REQ;
      endcase
    end else begin
      case (state_q)
        IFU_IDLE: if (credit_idle) state_q <= IFU_REQ;
        IFU_REQ: if (imem_req_ready_i) begin
          req_pc_q   <= fetch_pc_q;
          fetch_pc_q <= fetch_pc_q + 32'd4;
          state_q    <= IFU_WAIT;
        end
        IFU_WAIT: if (imem_resp_valid_i) state_q <= credit_push ? IFU_REQ : IFU_IDLE;
        default: if (imem_resp_valid_i) state_q <= IFU_REQ;
      endcase
    end
  end

  ysyx_22041412_ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({req_pc_q, imem_resp_data_i}),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign imem_req_valid_o = (state_q == IFU_REQ);
  assign imem_req_addr_o  = imem_req_valid_o ? fetch_pc_q : 32'd0;
  assign out_valid_o      = ~fifo_empty;
  assign out_pc_o         = out_valid_o ? fifo_head[63:32] : 32'd0;
  assign out_instr_o      = out_valid_o ? fifo_head[31:0]  : 32'd0;

`ifdef YSYX_22041412_IFU_PERF_EN
  logic [63:0] perf_fetch_q, perf_stall_q;

  // Delivered instructions (a pop during a flush still counts) and empty-output cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop)          perf_fetch_q <= perf_fetch_q + 64'd1;
      if (!out_valid_o) perf_stall_q <= perf_stall_q + 64'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Self-checking bench for the IFU: directed scenarios plus a randomized run.
// Reference: the decode-side stream must be consecutive word addresses from the
// last redirect target (or refetch point), each carrying mem_word(pc).
module tb_ysyx_22041412_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        fence_i_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_pc_o, out_instr_o;
`ifdef YSYX_22041412_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt_o, perf_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  ysyx_22041412_ifu dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .fence_i_i         (fence_i_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_pc_o          (out_pc_o),
    .out_instr_o       (out_instr_o)
`ifdef YSYX_22041412_IFU_PERF_EN
    ,
    .perf_fetch_cnt_o  (perf_fetch_cnt_o),
    .perf_stall_cnt_o  (perf_stall_cnt_o)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;
  int          lat_min, lat_max, ready_pct;
  int          deliv, stall_ticks;
  logic [31:0] last_deliv_pc, last_req_addr;
  bit          last_req_hs, obs_valid, obs_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: observe the cycle, update memory/stream model, then drive next-cycle inputs.
  task automatic tick();
    logic [31:0] refetch;
    #1;
    refetch     = exp_pc;
    last_req_hs = 1'b0;
    obs_valid   = out_valid_o;
    obs_req     = imem_req_valid_o;
    if (imem_resp_valid_i) mem_busy = 1'b0;
    if (imem_req_valid_o && imem_req_ready_i) begin
      chk("one_outstanding", 64'(mem_busy), 64'd0);
      chk("req_align", 64'(imem_req_addr_o[1:0]), 64'd0);
      mem_busy      = 1'b1;
      mem_addr      = imem_req_addr_o;
      mem_wait      = $urandom_range(lat_max, lat_min);
      last_req_hs   = 1'b1;
      last_req_addr = imem_req_addr_o;
    end
    if (!out_valid_o) stall_ticks++;
    if (out_valid_o && out_ready_i) begin
      chk("out_pc", 64'(out_pc_o), 64'(exp_pc));
      chk("out_instr", 64'(out_instr_o), 64'(mem_word(exp_pc)));
      last_deliv_pc = out_pc_o;
      deliv++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid_i)  exp_pc = redirect_pc_i[31:0] & 32'hFFFF_FFFC;
    else if (fence_i_i)    exp_pc = refetch;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    fence_i_i        = 1'b0;
    imem_resp_valid_i = 1'b0;
    if (mem_busy) begin
      if (mem_wait <= 1) begin
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = mem_word(mem_addr);
      end else mem_wait--;
    end
    imem_req_ready_i = ($urandom_range(99, 0) < ready_pct);
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
  endtask

  initial begin
    int first, d0, r;
    rst = 1'b1;
    imem_req_ready_i = 1'b1; imem_resp_valid_i = 1'b0; imem_resp_data_i = '0;
    redirect_valid_i = 1'b0; redirect_pc_i = '0; fence_i_i = 1'b0; out_ready_i = 1'b1;
    mem_busy = 0; mem_wait = 0; mem_addr = '0; lat_min = 1; lat_max = 1; ready_pct = 100;
    deliv = 0; stall_ticks = 0; last_deliv_pc = '0; last_req_addr = '0;
    exp_pc = 32'h8000_0000;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_pc", 64'(out_pc_o), 64'd0);
    chk("rst_out_instr", 64'(out_instr_o), 64'd0);
`ifdef YSYX_22041412_IFU_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt_o, 64'd0);
    chk("rst_perf_stall", perf_stall_cnt_o, 64'd0);
`endif
    rst = 1'b0;

    // 1: first fetches, latency 2 + 1 memory cycle, then 1 instr / 2 cycles
    tick();
    chk("idle_after_rst", 64'(obs_req), 64'd0);
    first = -1;
    for (int i = 1; i < 20 && first < 0; i++) begin
      tick();
      if (obs_valid) first = i;
    end
    chk("first_valid_latency", 64'(first), 64'd3);
    for (int i = 0; i < 20 && deliv < 3; i++) tick();
    chk("third_pc", 64'(last_deliv_pc), 64'h8000_0008);
    d0 = deliv;
    repeat (20) tick();
    chk("throughput", 64'(deliv - d0), 64'd10);

    // 2: decode stall fills exactly FIFO_DEPTH entries
    out_ready_i = 1'b0;
    repeat (10) tick();
    chk("stall_out_valid", 64'(out_valid_o), 64'd1);
    chk("stall_no_req", 64'(imem_req_valid_o), 64'd0);
    out_ready_i = 1'b1;
    d0 = deliv;
    tick(); tick();
    chk("stall_drain2", 64'(deliv - d0), 64'd2);
    tick();
    chk("stall_empty_after2", 64'(obs_valid), 64'd0);
    chk("resume_addr", 64'(last_req_addr), 64'(last_deliv_pc + 32'd4));

    // 3: redirect during WAIT with one buffered entry
    lat_min = 3; lat_max = 3; out_ready_i = 1'b0;
    for (int i = 0; i < 40 && !(last_req_hs && out_valid_o); i++) tick();
    do_redirect(64'h0000_1234_8000_0102);
    tick();
    chk("redir_fifo_cleared", 64'(out_valid_o), 64'd0);
    chk("redir_drain_no_req", 64'(imem_req_valid_o), 64'd0);
    lat_min = 1; lat_max = 1; out_ready_i = 1'b1;
    d0 = deliv;
    for (int i = 0; i < 40 && deliv == d0; i++) tick();
    chk("redir_target_pc", 64'(last_deliv_pc), 64'h8000_0100);

    // 4: redirect coincident with response
    for (int i = 0; i < 20 && !imem_resp_valid_i; i++) tick();
    do_redirect(64'h0000_0000_8000_0200);
    tick();
    chk("redir_resp_req", 64'(imem_req_valid_o), 64'd1);
    chk("redir_resp_addr", 64'(imem_req_addr_o), 64'h8000_0200);

    // Randomized traffic, backpressure, redirects and fence.i
    lat_min = 1; lat_max = 4; ready_pct = 60;
    for (int i = 0; i < 600; i++) begin
      out_ready_i = ($urandom_range(99, 0) < 70);
      r = $urandom_range(99, 0);
      if (r < 4)
        do_redirect({$urandom(), 32'h8000_0000 | ($urandom() & 32'h0000_FFFF)});
      else if (r < 7 && out_valid_o)
        fence_i_i = 1'b1;
      tick();
    end
    out_ready_i = 1'b1;
    tick();
`ifdef YSYX_22041412_IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt_o, 64'(deliv));
    chk("perf_stall", perf_stall_cnt_o, 64'(stall_ticks));
`endif

    // 5: fetch PC wraps to zero
    lat_min = 1; lat_max = 1; ready_pct = 100;
    do_redirect(64'h0000_0000_FFFF_FFFC);
    for (int i = 0; i < 20 && !(last_req_hs && last_req_addr == 32'hFFFF_FFFC); i++) tick();
    tick();
    for (int i = 0; i < 20 && !last_req_hs; i++) tick();
    chk("wrap_addr", 64'(last_req_addr), 64'd0);

    // Asynchronous reset while in WAIT
    for (int i = 0; i < 20 && !last_req_hs; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_req_valid", 64'(imem_req_valid_o), 64'd0);
    chk("arst_req_addr", 64'(imem_req_addr_o), 64'd0);
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_out_pc", 64'(out_pc_o), 64'd0);
    chk("arst_out_instr", 64'(out_instr_o), 64'd0);
    @(negedge clk);
    mem_busy = 1'b0; imem_resp_valid_i = 1'b0;
    exp_pc = 32'h8000_0000; deliv = 0; stall_ticks = 0; last_req_hs = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 20 && !last_req_hs; i++) tick();
    chk("restart_addr", 64'(last_req_addr), 64'h8000_0000);
    for (int i = 0; i < 20 && deliv == 0; i++) tick();
    chk("restart_pc", 64'(last_deliv_pc), 64'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
